// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the 8N1 serial receiver.
package serial_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } rx_state_e;

   localparam int RX_DATA_BITS   = 8;
   localparam int RX_MIN_SYM_CNT = 4;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchroniser for asynchronous pin inputs; resets to the idle-high level.
module rx_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/serial_rx_os.sv
// 8N1 LSB-first serial receiver with centre sampling; define RX_MAJORITY_EN for
// a 2-of-3 vote over the samples at H-1, H and H+1 instead of a single sample at H.
module serial_rx_os
   import serial_rx_pkg::*;
#(
   parameter int SCW     = 8,
   parameter int sym_cnt = 138
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_serial,
   output logic [7:0] rx_dat,
   output logic       rx_stb,
   output logic       rx_err
);

   localparam int             H        = sym_cnt / 2;
   localparam logic [SCW-1:0] CNT_LAST = SCW'(sym_cnt - 1);
   localparam logic [SCW-1:0] CNT_HM1  = SCW'(H - 1);
   localparam logic [SCW-1:0] CNT_H    = SCW'(H);
   localparam logic [SCW-1:0] CNT_HP1  = SCW'(H + 1);
   localparam logic [3:0]     BIT_LAST = 4'(RX_DATA_BITS - 1);

   generate
      if (sym_cnt < RX_MIN_SYM_CNT || sym_cnt > (2 ** SCW) - 1) begin : g_bad_sym_cnt
         $error("serial_rx_os: sym_cnt out of range for SCW");
      end
   endgenerate

   logic            rxs;
   rx_state_e       state_q, state_d;
   logic [SCW-1:0]  cnt_q, cnt_d;
   logic [3:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      dat_q, dat_d;
   logic            err_q, err_d;
   logic            stb_q, stb_d;
   logic            bit_val;
   logic            cnt_wrap;
   logic            decide;
   logic [SCW-1:0]  cnt_inc;

   rx_sync u_rx_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (rx_serial),
      .q_o   (rxs)
   );

   assign cnt_wrap = (cnt_q == CNT_LAST);
   assign cnt_inc  = cnt_wrap ? '0 : cnt_q + 1'b1;
   assign decide   = (cnt_q == CNT_HP1);

`ifdef RX_MAJORITY_EN
   logic s_hm1_q;
   logic s_h_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_hm1_q <= 1'b1;
         s_h_q   <= 1'b1;
      end else begin
         if (cnt_q == CNT_HM1) s_hm1_q <= rxs;
         if (cnt_q == CNT_H)   s_h_q   <= rxs;
      end
   end

   // Third vote is the live sample at H+1, the decision point.
   assign bit_val = maj3(s_hm1_q, s_h_q, rxs);
`else
   logic s_h_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_h_q <= 1'b1;
      end else if (cnt_q == CNT_H) begin
         s_h_q <= rxs;
      end
   end

   assign bit_val = s_h_q;
`endif

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      dat_d   = dat_q;
      err_d   = err_q;
      stb_d   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            bit_d = '0;
            // The detecting cycle is count 0 of the start bit, so START begins at 1.
            if (!rxs) begin
               state_d = ST_START;
               cnt_d   = SCW'(1);
            end
         end
         ST_START: begin
            cnt_d = cnt_inc;
            if (decide && bit_val) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_wrap) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            cnt_d = cnt_inc;
            if (decide) shift_d = {bit_val, shift_q[7:1]};
            if (cnt_wrap) begin
               if (bit_q == BIT_LAST) begin
                  state_d = ST_STOP;
                  bit_d   = '0;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
         ST_STOP: begin
            cnt_d = cnt_inc;
            // Leave mid stop bit so a following start edge is never missed.
            if (decide) begin
               dat_d   = shift_q;
               err_d   = ~bit_val;
               stb_d   = 1'b1;
               cnt_d   = '0;
               state_d = bit_val ? ST_IDLE : ST_BREAK;
            end
         end
         ST_BREAK: begin
            cnt_d = '0;
            if (rxs) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         dat_q   <= '0;
         err_q   <= 1'b0;
         stb_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         dat_q   <= dat_d;
         err_q   <= err_d;
         stb_q   <= stb_d;
      end
   end

   assign rx_dat = dat_q;
   assign rx_stb = stb_q;
   assign rx_err = err_q;

endmodule

// File: tb/tb_serial_rx_os.sv
// Scoreboard bench for serial_rx_os: a line driver queues the expected byte, error and strobe cycle per frame; a monitor checks strobes.
module tb_serial_rx_os;

   localparam int S = 16;
   localparam int H = S / 2;

   typedef struct {
      logic [7:0] dat;
      logic       err;
      int         cyc;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       rx_serial;
   logic [7:0] rx_dat;
   logic       rx_stb;
   logic       rx_err;

   int   cyc;
   int   tests;
   int   fails;
   exp_t sb_q[$];
   exp_t mon_e;

   serial_rx_os #(.SCW(8), .sym_cnt(S)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_serial (rx_serial),
      .rx_dat    (rx_dat),
      .rx_stb    (rx_stb),
      .rx_err    (rx_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Monitor: every strobe must match the oldest queued frame, including its cycle.
   always @(negedge clk) begin
      if (rst_n && rx_stb) begin
         if (sb_q.size() == 0) begin
            check("spurious_stb", 32'(rx_stb), 32'd0);
         end else begin
            mon_e = sb_q.pop_front();
            check("rx_dat", 32'(rx_dat), 32'(mon_e.dat));
            check("rx_err", 32'(rx_err), 32'(mon_e.err));
            check("stb_cycle", 32'(cyc), 32'(mon_e.cyc));
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle(input int n);
      rx_serial = 1'b1;
      step(n);
   endtask

   // Sends start, 8 data bits (LSB first) and stop at rate_pm/1000 clocks per bit;
   // the stop bit always lasts exactly S clocks. A glitch offset forces one high
   // cycle; an abort offset ends the frame early and queues nothing.
   task automatic send_frame(input logic [7:0] b, input logic stop, input int rate_pm,
                             input int glitch_off, input int abort_off, input logic [7:0] exp_dat);
      logic [9:0] bits;
      int         ends[10];
      int         n0;
      int         k;
      exp_t       e;
      bits = {stop, b, 1'b0};
      for (int i = 0; i < 9; i++) ends[i] = ((i + 1) * rate_pm) / 1000;
      ends[9] = (9 * rate_pm) / 1000 + S;
      n0 = cyc;
      if (abort_off < 0) begin
         e.dat = exp_dat;
         e.err = ~stop;
         // Line change is seen on rxs two cycles later (t0); strobe at t0 + 9S + H + 2.
         e.cyc = n0 + 2 + 9 * S + H + 2;
         sb_q.push_back(e);
      end
      k = 0;
      for (int off = 0; off < ends[9]; off++) begin
         while (off >= ends[k]) k++;
         if (off == abort_off) return;
         rx_serial = (off == glitch_off) ? 1'b1 : bits[k];
         step(1);
      end
   endtask

   initial begin
      logic [7:0] rb;
      logic       rstop;
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      rx_serial = 1'b1;
      #3;
      check("reset_dat", 32'(rx_dat), 32'h0);
      check("reset_err", 32'(rx_err), 32'h0);
      check("reset_stb", 32'(rx_stb), 32'h0);
      #10 rst_n = 1'b1;
      @(posedge clk);
      #1;
      idle(5);

      // Clean 0x55 frame.
      send_frame(8'h55, 1'b1, 16000, -1, -1, 8'h55);
      idle(10);

      // 3-cycle glitch; receiver must be idle again 10 cycles after it is seen.
      rx_serial = 1'b0;
      step(3);
      rx_serial = 1'b1;
      step(7);
      send_frame(8'h3C, 1'b1, 16000, -1, -1, 8'h3C);
      idle(10);

      // Framing error then a long break, then a clean frame.
      send_frame(8'hA3, 1'b0, 16000, -1, -1, 8'hA3);
      step(20 * S);
      idle(5);
      send_frame(8'h0F, 1'b1, 16000, -1, -1, 8'h0F);
      idle(10);

      // One-cycle high pulse at the centre of data bit 3.
`ifdef RX_MAJORITY_EN
      send_frame(8'h00, 1'b1, 16000, 4 * S + H, -1, 8'h00);
`else
      send_frame(8'h00, 1'b1, 16000, 4 * S + H, -1, 8'h08);
`endif
      idle(10);

      // Back-to-back frames at sender rates +4 % and -4 %.
      send_frame(8'h01, 1'b1, 15360, -1, -1, 8'h01);
      send_frame(8'hFE, 1'b1, 15360, -1, -1, 8'hFE);
      idle(10);
      send_frame(8'h01, 1'b1, 16640, -1, -1, 8'h01);
      send_frame(8'hFE, 1'b1, 16640, -1, -1, 8'hFE);
      idle(10);

      // Random bytes, stop bits, rates within tolerance and gaps.
      for (int i = 0; i < 24; i++) begin
         rb    = 8'($urandom);
         rstop = ($urandom_range(3, 0) != 0);
         send_frame(rb, rstop, int'($urandom_range(16600, 15400)), -1, -1, rb);
         idle(rstop ? int'($urandom_range(12, 0)) : int'($urandom_range(12, 2)));
      end

      // Leave non-zero outputs, then reset in the middle of data bit 4.
      send_frame(8'h5A, 1'b0, 16000, -1, -1, 8'h5A);
      idle(10);
      send_frame(8'h99, 1'b1, 16000, -1, 5 * S + H, 8'h99);
      rst_n = 1'b0;
      #1;
      check("midrst_dat", 32'(rx_dat), 32'h0);
      check("midrst_err", 32'(rx_err), 32'h0);
      check("midrst_stb", 32'(rx_stb), 32'h0);
      rx_serial = 1'b1;
      @(posedge clk);
      #1;
      step(3);
      rst_n = 1'b1;
      idle(5);
      send_frame(8'hC7, 1'b1, 16000, -1, -1, 8'hC7);
      idle(10);

      for (int w = 0; w < 2000 && sb_q.size() != 0; w++) step(1);
      check("pending_frames", 32'(sb_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/serial_rx_os.md
# serial_rx_os

Asynchronous serial receiver, 8N1, LSB first. Sits between the raw `rx` pin and the ACIA register file. It synchronises the line, finds the start bit, and samples each bit at its centre, with optional 3-sample majority voting. It hands each byte to the ACIA on the `rx_dat`/`rx_stb`/`rx_err` interface, which the ACIA uses to set its receive-full flag and error status bits.

## Interface
- `SCW`, default `8`: width of the bit-period counter; must be ≥ `$clog2(sym_cnt)`.
- `sym_cnt`, default `138`: clocks per bit (16 MHz / 115200); legal range 4 .. 2^SCW−1.
- `clk` input, 1: system clock; all logic on its rising edge.
- `rst_n` input, 1: reset, asynchronous and active-low.
- `rx_serial` input, 1: raw serial line, asynchronous to `clk`, idle high.
- `rx_dat` output, 8: last received byte.
- `rx_stb` output, 1: one-cycle strobe; `rx_dat` and `rx_err` are valid from this cycle on.
- `rx_err` output, 1: framing error flag for the last frame.

## Operation
- Synchroniser: two flops on `rx_serial`, both reset to 1. `rxs` is the second flop's output, and all logic below uses `rxs` only.
- Centre point: `H = sym_cnt/2`, integer division. Each bit is sampled at counter values `H−1`, `H` and `H+1`.
- Bit counter `cnt`, SCW bits:
  - counts 0 .. `sym_cnt−1` within each bit period, then wraps to 0;
  - is cleared on entry to START;
  - a 4-bit index counts data bits 0..7.
- IDLE → START: taken when `rxs == 0`. That cycle is `cnt = 0` of the start bit.
- START: at `cnt = H+1`, evaluate the voted bit.
  - Voted 1: false start. Go to IDLE, no strobe.
  - Voted 0: let `cnt` wrap, then go to DATA.
- DATA: at `H+1` of each bit, shift the voted value into bit 7 of the shift register (shift right, so bits arrive LSB first). After bit 7 wraps, go to STOP.
- STOP: at `cnt = H+1`:
  - load `rx_dat` from the shift register;
  - set `rx_err` to the inverse of the voted stop bit;
  - pulse `rx_stb`;
  - voted stop bit 1: go to IDLE immediately, without waiting for the end of the stop bit;
  - voted stop bit 0: go to BREAK.
- BREAK: wait for `rxs == 1`, then go to IDLE. No strobes are issued while the line stays low.
- `rx_err`: holds its value until the next completed frame overwrites it. A good frame clears it.
- Reset (`rst_n` low, at any time, including mid-frame): everything returns to reset values immediately. State goes to IDLE, `cnt` to 0, `rx_dat = 8'h00`, `rx_stb = 0`, `rx_err = 0`, synchroniser flops to 1.

## Timing
- Let `t0` be the first cycle in which `rxs == 0` in IDLE. `rxs` follows `rx_serial` with a 2-cycle delay.
- `rx_stb` is high for exactly the one cycle `t0 + 9*sym_cnt + H + 2`.
- `rx_dat` and `rx_err` change in that same cycle.
- `rx_stb` is registered.
- The earliest next start edge accepted is in cycle `t0 + 9*sym_cnt + H + 2`, while the strobe is high. Back-to-back frames with a full one-bit stop are therefore always received.
- Sender rate tolerance is about ±(H−1)/(10*sym_cnt), roughly ±4.9 % at the default `sym_cnt`.
- Outputs only change on `clk` edges, except for the asynchronous reset.

## Configuration
- `RX_MAJORITY_EN` defined: each bit value is the 2-of-3 majority of the samples at `H−1`, `H` and `H+1`.
- `RX_MAJORITY_EN` undefined: each bit value is the single sample at `cnt = H`.
  - The decision point stays at `H+1`, so all timing in this document is identical in both builds.
  - The vote registers are not built.

## Structure
- Package `serial_rx_pkg` holds:
  - the state enum: IDLE, START, DATA, STOP, BREAK;
  - `RX_DATA_BITS = 8`;
  - `RX_MIN_SYM_CNT = 4`.
- Sub-module `rx_sync`: 2-flop synchroniser with reset value 1 and asynchronous active-low reset. It is reused by any other pin input in the design.
- The top module contains the FSM, the counters, the vote logic and the output registers.
- An elaboration-time check rejects `sym_cnt < RX_MIN_SYM_CNT` and `sym_cnt > 2^SCW−1`.

## Test plan
- Clean frame, `sym_cnt = 16`, byte `0x55` → `rx_dat = 0x55`, `rx_err = 0`, `rx_stb` high for exactly one cycle at `t0 + 154`.
- 3-cycle low glitch on an idle line → no `rx_stb`, FSM back in IDLE by `t0 + 10`. A following clean `0x3C` frame is received correctly.
- Frame `0xA3` with stop bit 0, then line held low for 2 frame times, then a clean `0x0F`:
  - strobe 1: `0xA3` with `rx_err = 1`;
  - no strobe while the line stays low;
  - strobe 2: `0x0F` with `rx_err = 0`.
- Byte `0x00` with a 1-cycle high pulse at `cnt = H` of data bit 3 → `rx_dat = 0x00` with `RX_MAJORITY_EN`, `0x08` without it.
- Frames `0x01` and `0xFE` back to back, stop bit exactly `sym_cnt` long, at sender rates ±4 % → both bytes received, two strobes, `rx_err = 0`.
- `rst_n` pulsed low during data bit 4 → outputs read 0 immediately, no strobe for the interrupted frame. The next clean `0xC7` is received correctly.
